mem_port_arbiter: RTL and testbench

Shares one word-wide, multi-cycle backing memory port between the pipeline's instruction-fetch port and data-memory port. Presents the CPU with its existing busywait-style interfaces (instruction read, data read with 4-bit code, data write with 3-bit code). Performs byte-lane steering for stores and extraction/sign-extension for loads. Sits between cpu and the unified memory model at the top level.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/load_store_align.sv | 73 +++++++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and load/store code constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACC_I  = 3'd1,
        ST_ACC_D  = 3'd2,
        ST_DONE_I = 3'd3,
        ST_DONE_D = 3'd4
    } arb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_SB = 2'b00;
    localparam logic [1:0] SZ_SH = 2'b01;
    localparam logic [1:0] SZ_SW = 2'b10;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - combinational store lane steering and load extraction/extension
module load_store_align
    import mem_arb_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  st_size,
    input  logic [1:0]  req_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_byte_en,
    output logic [31:0] st_wdata,
    output logic        req_misalign,
    input  logic [2:0]  rd_funct3,
    input  logic [1:0]  rd_offset,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    always_comb begin
        st_byte_en = 4'b1111;
        st_wdata   = st_data;
        case (st_size)
            SZ_SB: begin
                st_byte_en = 4'b0001 << req_offset;
                st_wdata   = {4{st_data[7:0]}};
            end
            SZ_SH: begin
                st_byte_en = 4'b0011 << {req_offset[1], 1'b0};
                st_wdata   = {2{st_data[15:0]}};
            end
            default: begin
                st_byte_en = 4'b1111;
                st_wdata   = st_data;
            end
        endcase
    end

    // Undefined load codes and store size 11 are full-word accesses, so they share word alignment rules.
    always_comb begin
        req_misalign = 1'b0;
        if (is_load) begin
            case (ld_funct3)
                F3_LB, F3_LBU: req_misalign = 1'b0;
                F3_LH, F3_LHU: req_misalign = req_offset[0];
                default:       req_misalign = (req_offset != 2'b00);
            endcase
        end else begin
            case (st_size)
                SZ_SB:   req_misalign = 1'b0;
                SZ_SH:   req_misalign = req_offset[0];
                default: req_misalign = (req_offset != 2'b00);
            endcase
        end
    end

    assign byte_shift = rd_word >> {rd_offset, 3'b000};
    assign half_shift = rd_word >> {rd_offset[1], 4'b0000};

    always_comb begin
        rd_data = rd_word;
        case (rd_funct3)
            F3_LB:   rd_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            F3_LBU:  rd_data = {24'b0, byte_shift[7:0]};
            F3_LH:   rd_data = {{16{half_shift[15]}}, half_shift[15:0]};
            F3_LHU:  rd_data = {16'b0, half_shift[15:0]};
            default: rd_data = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one multi-cycle word memory port between instruction fetch and data access
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  INSTR_READ,
    input  logic [ADDR_WIDTH-1:0] INSTR_ADDR,
    output logic [31:0]           INSTRUCTION,
    output logic                  INSTR_MEM_BUSYWAIT,
    input  logic [3:0]            DATA_MEM_READ,
    input  logic [2:0]            DATA_MEM_WRITE,
    input  logic [ADDR_WIDTH-1:0] DATA_MEM_ADDR,
    input  logic [31:0]           DATA_MEM_WRITE_DATA,
    output logic [31:0]           DATA_MEM_READ_DATA,
    output logic                  DATA_MEM_BUSYWAIT,
    output logic                  DATA_MISALIGN,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [3:0]            MEM_BYTE_EN,
    output logic [31:0]           MEM_WRITEDATA,
    input  logic [31:0]           MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    arb_state_t    state, state_next;
    logic [CW-1:0] starve;
    logic          grant_d, grant_i;
    logic          data_req, is_load;

    logic [2:0]    funct3_q;
    logic [1:0]    offset_q;
    logic          load_q, misalign_q;

    logic [3:0]    st_be;
    logic [31:0]   st_wdata, ld_data;
    logic          req_misalign;
    logic          unused_ok;

    assign unused_ok = &{1'b0, INSTR_ADDR[1:0]};

    // A load wins over a simultaneous store, so the store bits are ignored whenever the load bit is set.
    assign is_load  = DATA_MEM_READ[3];
    assign data_req = DATA_MEM_READ[3] || DATA_MEM_WRITE[2];

    assign INSTR_MEM_BUSYWAIT = INSTR_READ && (state != ST_DONE_I);
    assign DATA_MEM_BUSYWAIT  = data_req && (state != ST_DONE_D);

    load_store_align u_align (
        .is_load      (is_load),
        .ld_funct3    (DATA_MEM_READ[2:0]),
        .st_size      (DATA_MEM_WRITE[1:0]),
        .req_offset   (DATA_MEM_ADDR[1:0]),
        .st_data      (DATA_MEM_WRITE_DATA),
        .st_byte_en   (st_be),
        .st_wdata     (st_wdata),
        .req_misalign (req_misalign),
        .rd_funct3    (funct3_q),
        .rd_offset    (offset_q),
        .rd_word      (MEM_READDATA),
        .rd_data      (ld_data)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_req && (!INSTR_READ || (starve < STARVE_MAX))) begin
                    grant_d    = 1'b1;
                    state_next = ST_ACC_D;
                end else if (INSTR_READ) begin
                    grant_i    = 1'b1;
                    state_next = ST_ACC_I;
                end
            end
            ST_ACC_I:  if (!MEM_BUSYWAIT) state_next = ST_DONE_I;
            ST_ACC_D:  if (!MEM_BUSYWAIT) state_next = ST_DONE_D;
            ST_DONE_I: state_next = ST_IDLE;
            ST_DONE_D: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            starve             <= '0;
            MEM_READ           <= 1'b0;
            MEM_WRITE          <= 1'b0;
            MEM_ADDR           <= '0;
            MEM_BYTE_EN        <= 4'b0;
            MEM_WRITEDATA      <= 32'b0;
            INSTRUCTION        <= 32'b0;
            DATA_MEM_READ_DATA <= 32'b0;
            DATA_MISALIGN      <= 1'b0;
            funct3_q           <= 3'b0;
            offset_q           <= 2'b0;
            load_q             <= 1'b0;
            misalign_q         <= 1'b0;
        end else begin
            DATA_MISALIGN <= (state == ST_ACC_D) && !MEM_BUSYWAIT && misalign_q;
            if (grant_d) begin
                MEM_READ      <= is_load;
                MEM_WRITE     <= !is_load;
                MEM_ADDR      <= {DATA_MEM_ADDR[ADDR_WIDTH-1:2], 2'b00};
                MEM_BYTE_EN   <= is_load ? 4'b0 : st_be;
                MEM_WRITEDATA <= is_load ? 32'b0 : st_wdata;
                funct3_q      <= DATA_MEM_READ[2:0];
                offset_q      <= DATA_MEM_ADDR[1:0];
                load_q        <= is_load;
                misalign_q    <= req_misalign;
                if (INSTR_READ) starve <= starve + 1'b1;
            end else if (grant_i) begin
                MEM_READ      <= 1'b1;
                MEM_WRITE     <= 1'b0;
                MEM_ADDR      <= {INSTR_ADDR[ADDR_WIDTH-1:2], 2'b00};
                MEM_BYTE_EN   <= 4'b0;
                MEM_WRITEDATA <= 32'b0;
                starve        <= '0;
            end
            // Completion captures even for withdrawn requests; the CPU simply never consumes that result.
            if (state == ST_ACC_I && !MEM_BUSYWAIT) begin
                INSTRUCTION <= MEM_READDATA;
                MEM_READ    <= 1'b0;
            end
            if (state == ST_ACC_D && !MEM_BUSYWAIT) begin
                if (load_q) DATA_MEM_READ_DATA <= ld_data;
                MEM_READ  <= 1'b0;
                MEM_WRITE <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter against a byte-level memory model
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        INSTR_READ;
    logic [31:0] INSTR_ADDR;
    logic [31:0] INSTRUCTION;
    logic        INSTR_MEM_BUSYWAIT;
    logic [3:0]  DATA_MEM_READ;
    logic [2:0]  DATA_MEM_WRITE;
    logic [31:0] DATA_MEM_ADDR;
    logic [31:0] DATA_MEM_WRITE_DATA;
    logic [31:0] DATA_MEM_READ_DATA;
    logic        DATA_MEM_BUSYWAIT;
    logic        DATA_MISALIGN;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_BYTE_EN;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_WIDTH(32)) dut (
        .CLK                 (CLK),
        .RESET_N             (RESET_N),
        .INSTR_READ          (INSTR_READ),
        .INSTR_ADDR          (INSTR_ADDR),
        .INSTRUCTION         (INSTRUCTION),
        .INSTR_MEM_BUSYWAIT  (INSTR_MEM_BUSYWAIT),
        .DATA_MEM_READ       (DATA_MEM_READ),
        .DATA_MEM_WRITE      (DATA_MEM_WRITE),
        .DATA_MEM_ADDR       (DATA_MEM_ADDR),
        .DATA_MEM_WRITE_DATA (DATA_MEM_WRITE_DATA),
        .DATA_MEM_READ_DATA  (DATA_MEM_READ_DATA),
        .DATA_MEM_BUSYWAIT   (DATA_MEM_BUSYWAIT),
        .DATA_MISALIGN       (DATA_MISALIGN),
        .MEM_READ            (MEM_READ),
        .MEM_WRITE           (MEM_WRITE),
        .MEM_ADDR            (MEM_ADDR),
        .MEM_BYTE_EN         (MEM_BYTE_EN),
        .MEM_WRITEDATA       (MEM_WRITEDATA),
        .MEM_READDATA        (MEM_READDATA),
        .MEM_BUSYWAIT        (MEM_BUSYWAIT)
    );

    // Backing memory: word array with programmable wait states; preloads go through pl_* so one process owns mem.
    logic [31:0] mem [0:255];
    int          wait_cycles = 0;
    int          acc_cnt = 0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_val = 32'd0;

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (acc_cnt < wait_cycles);
    assign MEM_READDATA = mem[MEM_ADDR[9:2]];

    always @(posedge CLK) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (MEM_READ || MEM_WRITE) begin
            if (MEM_BUSYWAIT) acc_cnt <= acc_cnt + 1;
            else begin
                acc_cnt <= 0;
                if (MEM_WRITE)
                    for (int k = 0; k < 4; k++)
                        if (MEM_BYTE_EN[k]) mem[MEM_ADDR[9:2]][8*k +: 8] <= MEM_WRITEDATA[8*k +: 8];
            end
        end else acc_cnt <= 0;
    end

    // Reference: byte-addressed little-endian memory updated by access rules, independent of lane enables.
    logic [7:0] refb [0:1023];

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge CLK);
        pl_en = 1'b1; pl_idx = 8'(idx); pl_val = val;
        for (int k = 0; k < 4; k++) refb[4*idx + k] = val[8*k +: 8];
        @(negedge CLK);
        pl_en = 1'b0;
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int a);
        int hb, wb;
        logic [7:0] b;
        logic [15:0] h;
        hb = a & ~1;
        wb = a & ~3;
        b = refb[a];
        h = {refb[hb + 1], refb[hb]};
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return {refb[wb + 3], refb[wb + 2], refb[wb + 1], refb[wb]};
        endcase
    endfunction

    function automatic logic exp_mis(input bit ld, input logic [2:0] f3, input logic [1:0] sz, input int a);
        int width;
        if (ld) width = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        else    width = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        return (a % width) != 0;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
        int width, base;
        width = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = a - (a % width);
        for (int k = 0; k < width; k++) refb[base + k] = wd[8*k +: 8];
    endtask

    task automatic data_txn(input bit ld, input logic [2:0] f3, input logic [1:0] sz, input int a,
                            input logic [31:0] wd, output logic [31:0] rdata, output logic mis,
                            output logic [3:0] be_seen, output logic [31:0] wd_seen,
                            output logic [31:0] ma_seen, output int acc_cycles, output bit ok);
        @(negedge CLK);
        DATA_MEM_READ       = ld ? {1'b1, f3} : 4'b0;
        DATA_MEM_WRITE      = ld ? 3'b0 : {1'b1, sz};
        DATA_MEM_ADDR       = 32'(a);
        DATA_MEM_WRITE_DATA = wd;
        ok = 1'b0; acc_cycles = 0; rdata = 'x; mis = 1'bx;
        be_seen = 'x; wd_seen = 'x; ma_seen = 'x;
        for (int c = 0; c < 200; c++) begin
            @(posedge CLK); #1;
            if (MEM_READ || MEM_WRITE) begin
                acc_cycles++;
                be_seen = MEM_BYTE_EN; wd_seen = MEM_WRITEDATA; ma_seen = MEM_ADDR;
            end
            if (!DATA_MEM_BUSYWAIT) begin
                ok = 1'b1; rdata = DATA_MEM_READ_DATA; mis = DATA_MISALIGN;
                break;
            end
        end
        DATA_MEM_READ  = 4'b0;
        DATA_MEM_WRITE = 3'b0;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; INSTR_READ = 1'b0; INSTR_ADDR = 32'd0;
        DATA_MEM_READ = 4'b0; DATA_MEM_WRITE = 3'b0; DATA_MEM_ADDR = 32'd0; DATA_MEM_WRITE_DATA = 32'd0;
        repeat (3) @(negedge CLK);
        n_cmp++; if (MEM_READ !== 1'b0) begin n_err++; $display("FAIL reset_mem_read got %b want 0", MEM_READ); end
        n_cmp++; if (MEM_WRITE !== 1'b0) begin n_err++; $display("FAIL reset_mem_write got %b want 0", MEM_WRITE); end
        n_cmp++; if (MEM_ADDR !== 32'd0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", MEM_ADDR); end
        n_cmp++; if (MEM_BYTE_EN !== 4'd0) begin n_err++; $display("FAIL reset_byte_en got %b want 0", MEM_BYTE_EN); end
        n_cmp++; if (MEM_WRITEDATA !== 32'd0) begin n_err++; $display("FAIL reset_writedata got %h want 0", MEM_WRITEDATA); end
        n_cmp++; if (INSTRUCTION !== 32'd0) begin n_err++; $display("FAIL reset_instruction got %h want 0", INSTRUCTION); end
        n_cmp++; if (DATA_MEM_READ_DATA !== 32'd0) begin n_err++; $display("FAIL reset_read_data got %h want 0", DATA_MEM_READ_DATA); end
        n_cmp++; if (DATA_MISALIGN !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b want 0", DATA_MISALIGN); end
        n_cmp++; if ({INSTR_MEM_BUSYWAIT, DATA_MEM_BUSYWAIT} !== 2'b00) begin n_err++; $display("FAIL reset_idle_busy got %b want 00", {INSTR_MEM_BUSYWAIT, DATA_MEM_BUSYWAIT}); end
        INSTR_READ = 1'b1; DATA_MEM_WRITE = 3'b100; #1;
        n_cmp++; if ({INSTR_MEM_BUSYWAIT, DATA_MEM_BUSYWAIT} !== 2'b11) begin n_err++; $display("FAIL reset_busy_follow got %b want 11", {INSTR_MEM_BUSYWAIT, DATA_MEM_BUSYWAIT}); end
        INSTR_READ = 1'b0; DATA_MEM_WRITE = 3'b0;
        @(negedge CLK); RESET_N = 1'b1;
        for (int i = 0; i < 256; i++) preload(i, $urandom);
    endtask

    task automatic test_fetch;
        int strobes;
        bit ok;
        preload(4, 32'h00A00093);
        wait_cycles = 2; strobes = 0; ok = 1'b0;
        @(negedge CLK); INSTR_ADDR = 32'h13; INSTR_READ = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge CLK); #1;
            if (MEM_READ) begin
                strobes++;
                n_cmp++; if (MEM_ADDR !== 32'h10) begin n_err++; $display("FAIL fetch_addr got %h want 00000010", MEM_ADDR); end
            end
            if (!INSTR_MEM_BUSYWAIT) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL fetch_timeout got no done want done"); end
        n_cmp++; if (INSTRUCTION !== 32'h00A00093) begin n_err++; $display("FAIL fetch_data got %h want 00a00093", INSTRUCTION); end
        n_cmp++; if (strobes !== 3) begin n_err++; $display("FAIL fetch_strobe_cycles got %0d want 3", strobes); end
        @(posedge CLK); #1;
        n_cmp++; if (INSTR_MEM_BUSYWAIT !== 1'b1) begin n_err++; $display("FAIL fetch_busy_one_cycle got %b want 1", INSTR_MEM_BUSYWAIT); end
        INSTR_READ = 1'b0;
    endtask

    task automatic test_bytes;
        logic [31:0] rd, wds, mas; logic mis; logic [3:0] be; int acc; bit ok;
        wait_cycles = 1;
        preload(8, 32'h0);
        data_txn(1'b0, 3'b0, 2'b00, 32'h23, 32'h000000F5, rd, mis, be, wds, mas, acc, ok);
        ref_store(2'b00, 32'h23, 32'h000000F5);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL sb_timeout got no done want done"); end
        n_cmp++; if (be !== 4'b1000) begin n_err++; $display("FAIL sb_byte_en got %b want 1000", be); end
        n_cmp++; if (wds !== 32'hF5F5F5F5) begin n_err++; $display("FAIL sb_writedata got %h want f5f5f5f5", wds); end
        n_cmp++; if (mas !== 32'h20) begin n_err++; $display("FAIL sb_addr got %h want 00000020", mas); end
        data_txn(1'b1, 3'b000, 2'b00, 32'h23, 32'h0, rd, mis, be, wds, mas, acc, ok);
        n_cmp++; if (rd !== 32'hFFFFFFF5) begin n_err++; $display("FAIL lb_sext got %h want fffffff5", rd); end
        data_txn(1'b1, 3'b100, 2'b00, 32'h23, 32'h0, rd, mis, be, wds, mas, acc, ok);
        n_cmp++; if (rd !== 32'h000000F5) begin n_err++; $display("FAIL lbu_zext got %h want 000000f5", rd); end
        data_txn(1'b0, 3'b0, 2'b01, 32'h22, 32'h00001234, rd, mis, be, wds, mas, acc, ok);
        ref_store(2'b01, 32'h22, 32'h00001234);
        n_cmp++; if ({be, wds} !== {4'b1100, 32'h12341234}) begin n_err++; $display("FAIL sh_steer got %b/%h want 1100/12341234", be, wds); end
        data_txn(1'b1, 3'b010, 2'b00, 32'h20, 32'h0, rd, mis, be, wds, mas, acc, ok);
        n_cmp++; if (rd !== 32'h12340000) begin n_err++; $display("FAIL lw_after_sh got %h want 12340000", rd); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd, wds, mas; logic mis; logic [3:0] be; int acc; bit ok;
        wait_cycles = 0;
        preload(32'h40, 32'hCAFEBABE);
        data_txn(1'b1, 3'b010, 2'b00, 32'h102, 32'h0, rd, mis, be, wds, mas, acc, ok);
        n_cmp++; if (mas !== 32'h100) begin n_err++; $display("FAIL mis_addr got %h want 00000100", mas); end
        n_cmp++; if (mis !== 1'b1) begin n_err++; $display("FAIL mis_pulse got %b want 1", mis); end
        n_cmp++; if (rd !== 32'hCAFEBABE) begin n_err++; $display("FAIL mis_data got %h want cafebabe", rd); end
        @(posedge CLK); #1;
        n_cmp++; if (DATA_MISALIGN !== 1'b0) begin n_err++; $display("FAIL mis_one_cycle got %b want 0", DATA_MISALIGN); end
    endtask

    task automatic test_contention;
        int d_at, i_at, n_data;
        logic [31:0] exp;
        wait_cycles = 1; d_at = -1; i_at = -1;
        preload(32'h10, 32'h11223344);
        @(negedge CLK);
        INSTR_READ = 1'b1; INSTR_ADDR = 32'h40;
        DATA_MEM_READ = 4'b1010; DATA_MEM_ADDR = 32'h80;
        exp = exp_load(3'b010, 32'h80);
        for (int c = 0; c < 100; c++) begin
            @(posedge CLK); #1;
            if (DATA_MEM_READ[3] && !DATA_MEM_BUSYWAIT) begin
                d_at = c;
                n_cmp++; if (DATA_MEM_READ_DATA !== exp) begin n_err++; $display("FAIL cont_data got %h want %h", DATA_MEM_READ_DATA, exp); end
                DATA_MEM_READ = 4'b0;
            end
            if (INSTR_READ && !INSTR_MEM_BUSYWAIT) begin i_at = c; INSTR_READ = 1'b0; end
            if (d_at >= 0 && i_at >= 0) break;
        end
        n_cmp++; if (!(d_at >= 0 && i_at > d_at)) begin n_err++; $display("FAIL cont_order got data@%0d fetch@%0d want data first", d_at, i_at); end
        n_cmp++; if (INSTRUCTION !== 32'h11223344) begin n_err++; $display("FAIL cont_fetch got %h want 11223344", INSTRUCTION); end

        n_data = 0; i_at = -1;
        @(negedge CLK);
        INSTR_READ = 1'b1; INSTR_ADDR = 32'h40;
        DATA_MEM_READ = 4'b1010; DATA_MEM_ADDR = 32'h0;
        for (int c = 0; c < 200; c++) begin
            @(posedge CLK); #1;
            if (!DATA_MEM_BUSYWAIT) begin
                exp = exp_load(3'b010, 4 * n_data);
                n_cmp++; if (DATA_MEM_READ_DATA !== exp) begin n_err++; $display("FAIL starve_data got %h want %h", DATA_MEM_READ_DATA, exp); end
                n_data++;
                DATA_MEM_ADDR = 32'(4 * n_data);
            end
            if (!INSTR_MEM_BUSYWAIT) begin i_at = c; break; end
        end
        INSTR_READ = 1'b0; DATA_MEM_READ = 4'b0;
        n_cmp++; if (i_at < 0 || n_data !== 4) begin n_err++; $display("FAIL starve_limit got %0d data grants (fetch@%0d) want 4", n_data, i_at); end
    endtask

    task automatic test_random;
        logic [2:0] f3tab [0:7];
        logic [31:0] rd, wds, mas, wd, e; logic mis; logic [3:0] be; int acc, a; bit ok, ld;
        logic [2:0] f3; logic [1:0] sz;
        f3tab[0] = 3'b000; f3tab[1] = 3'b001; f3tab[2] = 3'b010; f3tab[3] = 3'b100;
        f3tab[4] = 3'b101; f3tab[5] = 3'b011; f3tab[6] = 3'b110; f3tab[7] = 3'b111;
        for (int t = 0; t < 60; t++) begin
            wait_cycles = $urandom_range(0, 3);
            ld = 1'($urandom);
            f3 = f3tab[$urandom_range(0, 7)];
            sz = 2'($urandom);
            a = $urandom_range(0, 1023);
            wd = $urandom;
            data_txn(ld, f3, sz, a, wd, rd, mis, be, wds, mas, acc, ok);
            n_cmp++; if (!ok || mis !== exp_mis(ld, f3, sz, a)) begin n_err++; $display("FAIL rnd_misalign t=%0d got %b want %b", t, mis, exp_mis(ld, f3, sz, a)); end
            if (ld) begin
                e = exp_load(f3, a);
                n_cmp++; if (rd !== e) begin n_err++; $display("FAIL rnd_load t=%0d f3=%b a=%h got %h want %h", t, f3, a, rd, e); end
            end else ref_store(sz, a, wd);
        end
    endtask

    task automatic test_reset_mid_access;
        bit ok;
        preload(32'h11, 32'h5A5AA5A5);
        wait_cycles = 1000;
        @(negedge CLK);
        DATA_MEM_READ = 4'b1010; DATA_MEM_ADDR = 32'h0;
        INSTR_READ = 1'b1; INSTR_ADDR = 32'h44;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 32'h0) begin n_err++; $display("FAIL rst_pre_access got rd=%b addr=%h want 1/0", MEM_READ, MEM_ADDR); end
        @(negedge CLK); RESET_N = 1'b0; #1;
        n_cmp++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin n_err++; $display("FAIL rst_strobes got %b want 00", {MEM_READ, MEM_WRITE}); end
        n_cmp++; if (MEM_ADDR !== 32'h0 || INSTRUCTION !== 32'h0 || DATA_MEM_READ_DATA !== 32'h0) begin n_err++; $display("FAIL rst_outputs got %h/%h/%h want 0", MEM_ADDR, INSTRUCTION, DATA_MEM_READ_DATA); end
        DATA_MEM_READ = 4'b0; wait_cycles = 0; #1;
        n_cmp++; if (INSTR_MEM_BUSYWAIT !== 1'b1) begin n_err++; $display("FAIL rst_fetch_busy got %b want 1", INSTR_MEM_BUSYWAIT); end
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1; ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge CLK); #1;
            if (!INSTR_MEM_BUSYWAIT) begin ok = 1'b1; break; end
        end
        INSTR_READ = 1'b0;
        n_cmp++; if (!ok || INSTRUCTION !== 32'h5A5AA5A5) begin n_err++; $display("FAIL rst_fetch_after got %h (done=%b) want 5a5aa5a5", INSTRUCTION, ok); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_fetch;
        test_bytes;
        test_misalign;
        test_contention;
        test_random;
        test_reset_mid_access;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
